// File: rtl/dmem_store_unit.sv
// Store path from the MEM stage to data memory: lane alignment, byte enables, a small store FIFO and a req/ack issue stage.
// Optional macro STORE_HAZARD_EN enables the load-vs-pending-store word-address compare on ld_hazard.
module dmem_store_unit #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              st_valid,
  input  logic              st_byte,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  output logic              st_ready,
  output logic              misalign_err,
  output logic              st_idle,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [ADDR_W-1:0] ld_check_addr,
  output logic              ld_hazard
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, REQ} state_t;

  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [31:0]       fifo_data [DEPTH];
  logic [3:0]        fifo_be   [DEPTH];

  logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  state_t            state_reg;
  logic              mem_req_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [31:0]       mem_wdata_reg;
  logic [3:0]        mem_be_reg;
  logic              misalign_err_reg;

  logic              accept, misaligned, push, pop, fifo_nonempty;
  logic [ADDR_W-1:0] enq_addr;
  logic [31:0]       enq_data;
  logic [3:0]        enq_be;

  assign st_ready      = (count_reg != CW'(DEPTH));
  assign fifo_nonempty = (count_reg != '0);
  assign accept        = st_valid && st_ready;
  assign misaligned    = !st_byte && (st_addr[1:0] != 2'b00);
  assign push          = accept && !misaligned;
  // The output stage refills whenever it is empty or its current store is being acknowledged.
  assign pop           = fifo_nonempty && ((state_reg == IDLE) || mem_ack);

  assign enq_addr = {st_addr[ADDR_W-1:2], 2'b00};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign enq_data[8*gi +: 8] = st_byte ? st_data[7:0] : st_data[8*gi +: 8];
      assign enq_be[gi]          = !st_byte || (st_addr[1:0] == 2'(gi));
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr[wr_ptr_reg] <= enq_addr;
      fifo_data[wr_ptr_reg] <= enq_data;
      fifo_be[wr_ptr_reg]   <= enq_be;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      misalign_err_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg        <= count_reg + CW'(push) - CW'(pop);
      misalign_err_reg <= accept && misaligned;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      mem_req_reg   <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_be_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (fifo_nonempty) begin
            mem_addr_reg  <= fifo_addr[rd_ptr_reg];
            mem_wdata_reg <= fifo_data[rd_ptr_reg];
            mem_be_reg    <= fifo_be[rd_ptr_reg];
            mem_req_reg   <= 1'b1;
            state_reg     <= REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            if (fifo_nonempty) begin
              mem_addr_reg  <= fifo_addr[rd_ptr_reg];
              mem_wdata_reg <= fifo_data[rd_ptr_reg];
              mem_be_reg    <= fifo_be[rd_ptr_reg];
            end else begin
              mem_req_reg <= 1'b0;
              state_reg   <= IDLE;
            end
          end
        end
        default: begin
          mem_req_reg <= 1'b0;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

  assign st_idle      = !fifo_nonempty && (state_reg == IDLE);
  assign misalign_err = misalign_err_reg;
  assign mem_req      = mem_req_reg;
  assign mem_addr     = mem_addr_reg;
  assign mem_wdata    = mem_wdata_reg;
  assign mem_be       = mem_be_reg;

`ifdef STORE_HAZARD_EN
  logic [DEPTH-1:0] entry_hit;
  logic             unused_ld_low;

  // An entry is live when its distance from the read pointer is below the fill count.
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_hazard
      logic [PW-1:0] offset;
      assign offset        = PW'(gi) - rd_ptr_reg;
      assign entry_hit[gi] = (CW'(offset) < count_reg) &&
                             (fifo_addr[gi][ADDR_W-1:2] == ld_check_addr[ADDR_W-1:2]);
    end
  endgenerate

  assign ld_hazard = (|entry_hit) ||
                     (mem_req_reg && (mem_addr_reg[ADDR_W-1:2] == ld_check_addr[ADDR_W-1:2]));
  assign unused_ld_low = ^ld_check_addr[1:0];
`else
  logic unused_ld_check;
  assign unused_ld_check = ^ld_check_addr;
  assign ld_hazard       = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_store_unit.sv
// Randomized + directed bench for dmem_store_unit against a queue-level model of the store buffer.
module tb_dmem_store_unit;
  localparam int DEPTH  = 2;
  localparam int ADDR_W = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              st_valid, st_byte;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic              st_ready, misalign_err, st_idle, mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack;
  logic [ADDR_W-1:0] ld_check_addr;
  logic              ld_hazard;

  dmem_store_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .st_valid(st_valid), .st_byte(st_byte), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready), .misalign_err(misalign_err), .st_idle(st_idle),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .ld_check_addr(ld_check_addr), .ld_hazard(ld_hazard)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } st_t;

  // Model: stores waiting in the buffer, plus the one presented to memory.
  st_t q[$];
  st_t m_out;
  bit  m_out_valid;
  bit  m_mis;
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_out.addr  = '0;
    m_out.data  = '0;
    m_out.be    = '0;
    m_out_valid = 0;
    m_mis       = 0;
  endtask

  function automatic bit exp_hazard(input logic [31:0] lda);
`ifdef STORE_HAZARD_EN
    foreach (q[i]) if (q[i].addr[31:2] == lda[31:2]) return 1'b1;
    if (m_out_valid && m_out.addr[31:2] == lda[31:2]) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Applies the rules for one rising edge using the inputs present at that edge.
  task automatic model_edge();
    st_t e;
    bit  acc, bad, take;
    acc  = st_valid && (q.size() != DEPTH);
    bad  = acc && !st_byte && (st_addr[1:0] != 2'b00);
    take = (!m_out_valid || mem_ack) && (q.size() != 0);
    if (m_out_valid && mem_ack)
      $display("store done addr=%h data=%h be=%b", m_out.addr, m_out.data, m_out.be);
    if (take) begin
      m_out       = q.pop_front();
      m_out_valid = 1;
    end else if (m_out_valid && mem_ack) begin
      m_out_valid = 0;
    end
    if (acc && !bad) begin
      e.addr = st_addr & ~32'h3;
      if (st_byte) begin
        e.data = 32'h0101_0101 * {24'h0, st_data[7:0]};
        e.be   = 4'(1 << st_addr[1:0]);
      end else begin
        e.data = st_data;
        e.be   = 4'hF;
      end
      q.push_back(e);
    end
    m_mis = bad;
  endtask

  task automatic check_all();
    check_val("st_ready", st_ready, q.size() != DEPTH);
    check_val("st_idle", st_idle, (q.size() == 0) && !m_out_valid);
    check_val("misalign_err", misalign_err, m_mis);
    check_val("mem_req", mem_req, m_out_valid);
    check_val("mem_addr", mem_addr, m_out.addr);
    check_val("mem_wdata", mem_wdata, m_out.data);
    check_val("mem_be", mem_be, m_out.be);
    check_val("ld_hazard", ld_hazard, exp_hazard(ld_check_addr));
  endtask

  // Called at a falling edge: drive, advance one clock, then compare at the next falling edge.
  task automatic cycle(input logic v, input logic b, input logic [31:0] a, input logic [31:0] d,
                       input logic ack, input logic [31:0] lda);
    st_valid      = v;
    st_byte       = b;
    st_addr       = a;
    st_data       = d;
    mem_ack       = ack;
    ld_check_addr = lda;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all();
  endtask

  initial begin
    reset = 1'b1;
    st_valid = 0; st_byte = 0; st_addr = '0; st_data = '0; mem_ack = 0; ld_check_addr = '0;
    model_reset();
    repeat (2) @(negedge clock);
    check_all();
    reset = 1'b0;

    // Single word store, acked one cycle after mem_req
    cycle(1, 0, 32'h100, 32'hDEAD_BEEF, 0, 32'h102);
    cycle(0, 0, 32'h0, 32'h0, 0, 32'h104);
    cycle(0, 0, 32'h0, 32'h0, 1, 32'h100);
    cycle(0, 0, 32'h0, 32'h0, 0, 32'h100);

    // Byte lanes 3,0,1,2, each drained before the next
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, 32'h200 + 32'((i + 3) % 4), 32'h0000_00A5 + 32'(i), 0, 32'h200);
      cycle(0, 0, 32'h0, 32'h0, 0, 32'h200);
      cycle(0, 0, 32'h0, 32'h0, 1, 32'h200);
    end

    // Backpressure: four back-to-back pushes with no ack, then ack each
    for (int i = 0; i < 4; i++)
      cycle(1, 0, 32'h300 + 32'(4 * i), 32'h1111_0000 + 32'(i), 0, 32'h308);
    for (int i = 0; i < 4; i++)
      cycle(0, 0, 32'h0, 32'h0, 1, 32'h304);

    // Misaligned word store
    cycle(1, 0, 32'h102, 32'h1234_5678, 0, 32'h100);
    cycle(0, 0, 32'h0, 32'h0, 0, 32'h100);
    cycle(0, 0, 32'h0, 32'h0, 0, 32'h100);

    // Reset between edges with stores in flight
    cycle(1, 0, 32'h400, 32'hAAAA_0001, 0, 32'h0);
    cycle(1, 0, 32'h404, 32'hAAAA_0002, 0, 32'h0);
    cycle(1, 0, 32'h408, 32'hAAAA_0003, 0, 32'h0);
    st_valid = 0;
    reset = 1'b1;
    #1;
    check_val("rst_mem_req", mem_req, 1'b0);
    check_val("rst_st_ready", st_ready, 1'b1);
    check_val("rst_st_idle", st_idle, 1'b1);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++)
      cycle(0, 0, 32'h0, 32'h0, 1'(i), 32'h400);

    // Random traffic over a small address window so hazards and reuse occur
    for (int i = 0; i < 600; i++) begin
      logic        b;
      logic [31:0] a;
      b = 1'($urandom_range(0, 1));
      a = 32'h500 + 32'(4 * $urandom_range(0, 7));
      if (b || $urandom_range(0, 4) == 0) a = a + 32'($urandom_range(0, 3));
      cycle(1'($urandom_range(0, 9) < 6), b, a, $urandom,
            1'($urandom_range(0, 1)),
            32'h500 + 32'($urandom_range(0, 31)));
    end

    // Drain
    for (int i = 0; i < 6; i++)
      cycle(0, 0, 32'h0, 32'h0, 1, 32'h500);
    check_val("final_idle", st_idle, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
